image_host_ctrl: RTL
====================

IMAGE_HOST_CTRL -- requirements
Module: image_host_ctrl

Interface
REQ-001 SHALL have parameter IN_COUNT, default 65536, number of input pixels loaded (256x256).
REQ-002 SHALL have parameter OUT_COUNT, default 16129, number of result pixels read back (127x127).
REQ-003 SHALL have parameter RD_WAIT, default 2, cycles between cpu_addr update and cpu_out capture.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1048576, watchdog limit for the processing phase.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle pulse that begins load, process and readout.
REQ-008 s_valid / s_data / s_ready  in / in[8] / out  input pixel stream, valid-ready.
REQ-009 cpu_status  out  2  CPU mode: 00 idle, 10 load, 01 process, 11 readout.
REQ-010 cpu_addr  out  16  CPU memory address.
REQ-011 cpu_data  out  8  pixel written to CPU memory in load mode.
REQ-012 cpu_end  in  1  CPU end_process flag.
REQ-013 cpu_out  in  8  CPU result byte for the current cpu_addr.
REQ-014 m_valid / m_data / m_ready  out / out[8] / in  result stream, valid-ready.
REQ-015 busy, done, err  out  1 each  sequence active; sequence completed; watchdog fired.

Function
REQ-016 SHALL implement states IDLE, LOAD, FLUSH, PROC, RADDR, RWAIT, SEND, DONE, ERR; all outputs SHALL be registered.
REQ-017 IDLE/DONE/ERR: start=1 -> LOAD next cycle; done and err clear and busy sets on that transition; start SHALL be ignored in every other state.
REQ-018 LOAD: cpu_status=10 and s_ready=1. Each s_valid&s_ready beat SHALL register cpu_data<=s_data and cpu_addr<=beat index (0..IN_COUNT-1), both held until the next beat.
REQ-019 On the beat with index IN_COUNT-1: s_ready SHALL deassert the next cycle, and the state SHALL go to FLUSH, holding cpu_status=10 for one cycle so the last write lands.
REQ-020 FLUSH -> PROC: cpu_status=01 and cpu_addr=0; stay in PROC until cpu_end=1.
REQ-021 PROC with cpu_end=1 -> RADDR: cpu_status=11 and cpu_addr=0.
REQ-022 RADDR -> RWAIT. RWAIT SHALL count RD_WAIT cycles, then register m_data<=cpu_out, set m_valid=1 and go to SEND.
REQ-023 SEND: m_valid and m_data SHALL stay stable while m_ready=0. On the handshake, m_valid SHALL drop. If the index is below OUT_COUNT-1, cpu_addr increments and the state goes to RADDR; otherwise it goes to DONE.
REQ-024 DONE: cpu_status=00, done=1, busy=0. done SHALL hold until the next start.
REQ-025 The throughput minimum SHALL be one input beat per cycle in LOAD, and one output byte per RD_WAIT+2 cycles in readout.
REQ-026 The beat and output counters SHALL be 17 bits wide; cpu_addr SHALL be the low 16 bits and SHALL never wrap within a phase.
REQ-027 s_valid outside LOAD SHALL be ignored with s_ready=0; m_ready outside SEND SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, cpu_status=00, cpu_addr=0, cpu_data=0, s_ready=0, m_valid=0, m_data=0, busy=0, done=0, err=0, and all counters and the watchdog to 0.
REQ-029 Reset mid-sequence SHALL abandon the sequence without emitting a partial beat; the next start SHALL restart from pixel 0.

Configuration
REQ-030 Macro HOST_CTRL_TIMEOUT_EN defined: a watchdog SHALL count cycles in PROC. On reaching TIMEOUT_CYCLES without cpu_end, it SHALL go to ERR with cpu_status=00, err=1, busy=0, and no output beats.
REQ-031 Macro HOST_CTRL_TIMEOUT_EN undefined: there SHALL be no watchdog logic, err SHALL be tied to 0, and PROC SHALL wait indefinitely.

Verification
REQ-032 Full run: start, 65536 bytes with value (i mod 256) and s_valid always high -> cpu_addr 0..65535 in 65536 cycles; FLUSH; cpu_status 10->01; cpu_end after 500 cycles -> 16129 m_data beats equal to the model cpu_out, then done=1.
REQ-033 Input bubbles: s_valid toggled 50% randomly -> cpu_data/cpu_addr change only on handshake beats, and the write sequence is identical to REQ-032.
REQ-034 Output backpressure: m_ready low for 10 cycles on beat 5 -> m_data and cpu_addr held stable, with no beat lost or duplicated.
REQ-035 Reset asserted at load beat 1000 -> all outputs equal the REQ-028 values immediately; a new start reloads from cpu_addr 0.
REQ-036 With HOST_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, cpu_end held 0 -> err=1 exactly 100 cycles after PROC entry, with m_valid never 1.
REQ-037 start pulsed during LOAD and PROC -> ignored, with the beat count and state unaffected.

Source files
------------

// File: rtl/image_host_ctrl_if.sv
// ---------------------------------------------------------------------------
// image_host_ctrl_if
//   Bundles the pixel input stream, the result output stream and the CPU
//   memory bus used by image_host_ctrl.
//   slave  : controller side (image_host_ctrl)
//   master : environment side (pixel source, result sink, CPU)
//   Signals:
//     s_valid/s_data/s_ready  input pixel stream (valid-ready)
//     m_valid/m_data/m_ready  result stream (valid-ready)
//     cpu_status[1:0]         CPU mode: 00 idle, 10 load, 01 process, 11 readout
//     cpu_addr[15:0]          CPU memory address
//     cpu_data[7:0]           pixel written to CPU memory in load mode
//     cpu_end                 CPU end_process flag
//     cpu_out[7:0]            CPU result byte for the current cpu_addr
// ---------------------------------------------------------------------------
interface image_host_ctrl_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [1:0]  cpu_status;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_end;
  logic [7:0]  cpu_out;

  modport slave (
    input  s_valid, s_data, m_ready, cpu_end, cpu_out,
    output s_ready, m_valid, m_data, cpu_status, cpu_addr, cpu_data
  );

  modport master (
    output s_valid, s_data, m_ready, cpu_end, cpu_out,
    input  s_ready, m_valid, m_data, cpu_status, cpu_addr, cpu_data
  );
endinterface

// File: rtl/image_host_ctrl.sv
// ---------------------------------------------------------------------------
// image_host_ctrl
//   Host-side sequencer for an image-processing CPU: on a start pulse it
//   streams IN_COUNT pixels into CPU memory, lets the CPU process until it
//   raises cpu_end, then reads OUT_COUNT result bytes back and emits them on
//   a valid-ready stream.
//   Ports:
//     clk     sole clock, rising edge
//     rst_n   asynchronous active-low reset
//     start   single-cycle pulse, honoured only in IDLE/DONE/ERR
//     bus     image_host_ctrl_if.slave (pixel stream, result stream, CPU bus)
//     busy    sequence active
//     done    sequence completed, held until the next start
//     err     processing watchdog fired
//   Build option:
//     HOST_CTRL_TIMEOUT_EN  when defined, a watchdog aborts PROC to ERR after
//                           TIMEOUT_CYCLES cycles without cpu_end; otherwise
//                           err is tied low and PROC waits indefinitely.
// ---------------------------------------------------------------------------
module image_host_ctrl #(
  parameter int unsigned IN_COUNT       = 65536,
  parameter int unsigned OUT_COUNT      = 16129,
  parameter int unsigned RD_WAIT        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  image_host_ctrl_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [16:0] IN_LAST   = 17'(IN_COUNT - 1);
  localparam logic [16:0] OUT_LAST  = 17'(OUT_COUNT - 1);
  // A read wait of zero is treated as one cycle so RWAIT always terminates.
  localparam int unsigned WAIT_N    = (RD_WAIT == 0) ? 1 : RD_WAIT;
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_N - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, FLUSH, PROC, RADDR, RWAIT, SEND, DONE, ERR
  } state_t;

  state_t      r_state,      w_state_nx;
  logic [1:0]  r_cpu_status, w_cpu_status_nx;
  logic [15:0] r_cpu_addr,   w_cpu_addr_nx;
  logic [7:0]  r_cpu_data,   w_cpu_data_nx;
  logic        r_s_ready,    w_s_ready_nx;
  logic        r_m_valid,    w_m_valid_nx;
  logic [7:0]  r_m_data,     w_m_data_nx;
  logic        r_busy,       w_busy_nx;
  logic        r_done,       w_done_nx;
  logic [16:0] r_beat,       w_beat_nx;
  logic [16:0] r_oidx,       w_oidx_nx;
  logic [16:0] w_oidx_inc;
  logic [15:0] r_wait,       w_wait_nx;

`ifdef HOST_CTRL_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_wdog, w_wdog_nx;
  logic        r_err,  w_err_nx;
`endif

  assign w_oidx_inc = r_oidx + 17'd1;

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    w_state_nx      = r_state;
    w_cpu_status_nx = r_cpu_status;
    w_cpu_addr_nx   = r_cpu_addr;
    w_cpu_data_nx   = r_cpu_data;
    w_s_ready_nx    = r_s_ready;
    w_m_valid_nx    = r_m_valid;
    w_m_data_nx     = r_m_data;
    w_busy_nx       = r_busy;
    w_done_nx       = r_done;
    w_beat_nx       = r_beat;
    w_oidx_nx       = r_oidx;
    w_wait_nx       = r_wait;
`ifdef HOST_CTRL_TIMEOUT_EN
    w_wdog_nx       = r_wdog;
    w_err_nx        = r_err;
`endif

    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_state_nx      = LOAD;
          w_cpu_status_nx = 2'b10;
          w_s_ready_nx    = 1'b1;
          w_busy_nx       = 1'b1;
          w_done_nx       = 1'b0;
          w_beat_nx       = '0;
`ifdef HOST_CTRL_TIMEOUT_EN
          w_err_nx        = 1'b0;
`endif
        end
      end

      LOAD: begin
        if (bus.s_valid && r_s_ready) begin
          w_cpu_data_nx = bus.s_data;
          w_cpu_addr_nx = r_beat[15:0];
          if (r_beat == IN_LAST) begin
            w_s_ready_nx = 1'b0;
            w_state_nx   = FLUSH;
          end else begin
            w_beat_nx = r_beat + 17'd1;
          end
        end
      end

      // cpu_status stays 10 here so the final pixel is written.
      FLUSH: begin
        w_state_nx      = PROC;
        w_cpu_status_nx = 2'b01;
        w_cpu_addr_nx   = '0;
`ifdef HOST_CTRL_TIMEOUT_EN
        w_wdog_nx       = '0;
`endif
      end

      PROC: begin
        if (bus.cpu_end) begin
          w_state_nx      = RADDR;
          w_cpu_status_nx = 2'b11;
          w_cpu_addr_nx   = '0;
          w_oidx_nx       = '0;
        end
`ifdef HOST_CTRL_TIMEOUT_EN
        else if (r_wdog == TO_LAST) begin
          w_state_nx      = ERR;
          w_cpu_status_nx = 2'b00;
          w_err_nx        = 1'b1;
          w_busy_nx       = 1'b0;
        end else begin
          w_wdog_nx = r_wdog + 32'd1;
        end
`endif
      end

      RADDR: begin
        w_state_nx = RWAIT;
        w_wait_nx  = '0;
      end

      RWAIT: begin
        if (r_wait == WAIT_LAST) begin
          w_m_data_nx  = bus.cpu_out;
          w_m_valid_nx = 1'b1;
          w_state_nx   = SEND;
        end else begin
          w_wait_nx = r_wait + 16'd1;
        end
      end

      SEND: begin
        if (bus.m_ready) begin
          w_m_valid_nx = 1'b0;
          if (r_oidx < OUT_LAST) begin
            w_oidx_nx     = w_oidx_inc;
            w_cpu_addr_nx = w_oidx_inc[15:0];
            w_state_nx    = RADDR;
          end else begin
            w_state_nx      = DONE;
            w_cpu_status_nx = 2'b00;
            w_done_nx       = 1'b1;
            w_busy_nx       = 1'b0;
          end
        end
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cpu_status <= '0;
      r_cpu_addr   <= '0;
      r_cpu_data   <= '0;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_beat       <= '0;
      r_oidx       <= '0;
      r_wait       <= '0;
`ifdef HOST_CTRL_TIMEOUT_EN
      r_wdog       <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_cpu_status <= w_cpu_status_nx;
      r_cpu_addr   <= w_cpu_addr_nx;
      r_cpu_data   <= w_cpu_data_nx;
      r_s_ready    <= w_s_ready_nx;
      r_m_valid    <= w_m_valid_nx;
      r_m_data     <= w_m_data_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_beat       <= w_beat_nx;
      r_oidx       <= w_oidx_nx;
      r_wait       <= w_wait_nx;
`ifdef HOST_CTRL_TIMEOUT_EN
      r_wdog       <= w_wdog_nx;
      r_err        <= w_err_nx;
`endif
    end
  end

  assign bus.cpu_status = r_cpu_status;
  assign bus.cpu_addr   = r_cpu_addr;
  assign bus.cpu_data   = r_cpu_data;
  assign bus.s_ready    = r_s_ready;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_data     = r_m_data;
  assign busy           = r_busy;
  assign done           = r_done;

`ifdef HOST_CTRL_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
